// File: rtl/inv_key_schedule.sv
// inv_key_schedule: AES-128 decryption-side key sequencer.
// Starting from the final round key, it regenerates the round keys in reverse order
// (NUM_ROUNDS down to 0) and presents one key per valid/ready handshake.
// Optional build macro INV_KS_KEY_CHECK_EN adds orig_key/key_match, which check
// that the unwound round-0 key equals the expected cipher key.
module inv_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [0:3][31:0] last_key,
    input  logic             key_ready,
`ifdef INV_KS_KEY_CHECK_EN
    input  logic [0:3][31:0] orig_key,
    output logic             key_match,
`endif
    output logic             key_valid,
    output logic [0:3][31:0] round_key,
    output logic [3:0]       round_num,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, OUT = 1'b1} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        case (rnd)
            4'd1:  r = 8'h01;
            4'd2:  r = 8'h02;
            4'd3:  r = 8'h04;
            4'd4:  r = 8'h08;
            4'd5:  r = 8'h10;
            4'd6:  r = 8'h20;
            4'd7:  r = 8'h40;
            4'd8:  r = 8'h80;
            4'd9:  r = 8'h1b;
            4'd10: r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Undo one step of the forward key expansion: round rnd key -> round rnd-1 key.
    function automatic logic [0:3][31:0] prev_key(input logic [0:3][31:0] w, input logic [3:0] rnd);
        logic [0:3][31:0] p;
        logic [31:0]      t;
        p[3] = w[3] ^ w[2];
        p[2] = w[2] ^ w[1];
        p[1] = w[1] ^ w[0];
        t    = {p[3][23:0], p[3][31:24]};
        t    = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
        p[0] = w[0] ^ t ^ {rcon(rnd), 24'h0};
        return p;
    endfunction

    state_t state, state_nxt;
    logic   load, hs, last_hs;

    assign load      = (state == IDLE) && start;
    assign hs        = (state == OUT) && key_ready;
    assign last_hs   = hs && (round_num == 4'd0);
    assign key_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: leave IDLE on start, return after the round-0 key is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = OUT;
            OUT:     if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Key/round registers: load on start, step back one round on each handshake.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            round_key <= '0;
            round_num <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= last_hs;
            if (load) begin
                round_key <= last_key;
                round_num <= 4'(NUM_ROUNDS);
            end else if (hs && (round_num != 4'd0)) begin
                round_key <= prev_key(round_key, round_num);
                round_num <= round_num - 4'd1;
            end
        end
    end

`ifdef INV_KS_KEY_CHECK_EN
    // Compare the final unwound key against the expected cipher key.
    always_ff @(posedge clk) begin
        if (!n_rst)       key_match <= 1'b0;
        else if (load)    key_match <= 1'b0;
        else if (last_hs) key_match <= (round_key == orig_key);
    end
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Testbench for inv_key_schedule: random keys are expanded forward with a reference
// AES-128 key expansion (S-box derived from GF(2^8) arithmetic) and the DUT's reverse
// sequence is compared against the expanded words. Honors INV_KS_KEY_CHECK_EN.
module tb_inv_key_schedule;

    localparam int NR = 10;

    logic             clk = 1'b0;
    logic             n_rst, start, key_ready;
    logic [0:3][31:0] last_key;
    logic             key_valid, busy, done;
    logic [0:3][31:0] round_key;
    logic [3:0]       round_num;
`ifdef INV_KS_KEY_CHECK_EN
    logic [0:3][31:0] orig_key;
    logic             key_match;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int run_id = 0;

    logic [7:0]  sb [0:255];
    logic [31:0] ew [0:43];

    always #5 clk = ~clk;

    inv_key_schedule #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .last_key(last_key), .key_ready(key_ready),
`ifdef INV_KS_KEY_CHECK_EN
        .orig_key(orig_key), .key_match(key_match),
`endif
        .key_valid(key_valid), .round_key(round_key), .round_num(round_num),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Forward AES-128 key expansion into ew[0..43].
    task automatic expand_key(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) ew[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ew[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t  = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ew[i] = ew[i-4] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_exp(input int r);
        return {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
    endfunction

    // One full sequence from key ok. stall_rnd: hold ready low 5 cycles there;
    // start_rnd: pulse start mid-sequence; reset_rnd: reset there; chain: restart on done.
    task automatic run_seq(input logic [127:0] ok, input int stall_pct, input int stall_rnd,
                           input int start_rnd, input int reset_rnd, input bit chain);
        int  exp, cyc, stalls;
        bit  hs, again, ch;
        expand_key(ok);
        ch = chain;
        run_id++;
`ifdef INV_KS_KEY_CHECK_EN
        orig_key = (run_id % 2 == 0) ? ok : (ok ^ (128'h1 << $urandom_range(0, 127)));
`endif
        last_key  = rk_exp(NR);
        start     = 1'b1;
        step();
        start     = 1'b0;
        again     = 1'b1;
        while (again) begin
            again = 1'b0; exp = NR; cyc = 0; stalls = 0;
            while (exp >= 0) begin
                if (cyc > 400) begin
                    chk("timeout", cyc, 0);
                    break;
                end
                chk("valid", key_valid, 1);
                chk("busy", busy, 1);
                chk("done_low", done, 0);
                chk("round_num", round_num, exp);
                chk("round_key", round_key, rk_exp(exp));
                if (exp == reset_rnd) begin
                    n_rst = 1'b0; key_ready = 1'b1;
                    step();
                    n_rst = 1'b1; key_ready = 1'b0;
                    chk("rst_valid", key_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_rnum", round_num, 0);
                    chk("rst_rkey", round_key, 0);
                    step();
                    chk("rst_nodone", done, 0);
                    chk("rst_idle", key_valid, 0);
                    return;
                end
                if (exp == stall_rnd && stalls < 5) begin
                    key_ready = 1'b0;
                    stalls++;
                end else begin
                    key_ready = ($urandom_range(0, 99) >= stall_pct);
                end
                hs    = key_ready;
                start = (exp == start_rnd);
                step();
                start = 1'b0;
                cyc++;
                if (hs) exp--;
            end
            key_ready = 1'b0;
            chk("done_pulse", done, 1);
            chk("end_valid", key_valid, 0);
            chk("end_busy", busy, 0);
`ifdef INV_KS_KEY_CHECK_EN
            chk("key_match", key_match, (orig_key == ok));
`endif
            if (ch) begin
                ch = 1'b0; again = 1'b1;
                start = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
                chk("done_once", done, 0);
            end
        end
    endtask

    initial begin
        logic [127:0] fips_key;
        fips_key  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        n_rst = 1'b0; start = 1'b0; key_ready = 1'b0; last_key = '0;
`ifdef INV_KS_KEY_CHECK_EN
        orig_key = '0;
`endif
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        chk("sbox_00", sb[0], 8'h63);
        chk("sbox_53", sb[8'h53], 8'hed);

        step();
        step();
        chk("reset_valid", key_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rnum", round_num, 0);
        chk("reset_rkey", round_key, 0);
        n_rst = 1'b1;
        step();
        chk("idle_valid", key_valid, 0);

        // Known-answer sequence with ready held high.
        last_key = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
`ifdef INV_KS_KEY_CHECK_EN
        orig_key = fips_key;
`endif
        start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r <= NR; r++) begin
            chk("fips_valid", key_valid, 1);
            chk("fips_rnum", round_num, NR - r);
            if (r == 0)  chk("fips_r10", round_key, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
            if (r == 1)  chk("fips_r9",  round_key, 128'hac7766f3_19fadc21_28d12941_575c006e);
            if (r == NR) chk("fips_r0",  round_key, fips_key);
            step();
        end
        key_ready = 1'b0;
        chk("fips_done", done, 1);
        chk("fips_valid_end", key_valid, 0);
`ifdef INV_KS_KEY_CHECK_EN
        chk("fips_match", key_match, 1);
`endif
        step();
        chk("fips_done_once", done, 0);

        run_seq(fips_key, 0, -1, -1, -1, 1'b0);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 0, 7, -1, -1, 1'b0);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 0, -1, 4, -1, 1'b0);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 5, 1'b0);
        run_seq({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, -1, 1'b1);
        for (int n = 0; n < 6; n++)
            run_seq({$urandom, $urandom, $urandom, $urandom}, 40, -1, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
